// File: rtl/cpu_step1.sv
// rtl/cpu_step1.sv - instruction-fetch stage: PC, IF/ID register, stall/redirect/HALT control
module cpu_step1 #(
    parameter int              PC_W      = 10,
    parameter int              DW        = 16,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter logic [DW-1:0]   NOP_INSTR = '0,
    parameter logic [5:0]      HALT_OP   = 6'h3F
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            stall,
    input  logic            pc_redirect,
    input  logic [PC_W-1:0] pc_target,
    output logic [PC_W-1:0] im_addr,
    input  logic [DW-1:0]   im_data,
    output logic [DW-1:0]   im_instr,
    output logic [PC_W-1:0] if_pc,
    output logic            if_valid,
    output logic            halted
);

    localparam logic [1:0] ST_START = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    logic [1:0]      state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic            is_halt;

    assign pc_inc  = pc + 1'b1;
    assign is_halt = (im_data[DW-1 -: 6] == HALT_OP);
    assign im_addr = pc;
    assign halted  = (state == ST_HALT);

    // Redirect beats stall in both RUN and HALT: the older branch outranks any hazard.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_START;
            pc       <= RESET_PC;
            im_instr <= NOP_INSTR;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else begin
            case (state)
                ST_START: begin
                    im_instr <= NOP_INSTR;
                    if_valid <= 1'b0;
                    state    <= ST_RUN;
                end
                ST_RUN: begin
                    if (pc_redirect) begin
                        pc       <= pc_target;
                        im_instr <= NOP_INSTR;
                        if_valid <= 1'b0;
                    end else if (!stall) begin
                        im_instr <= im_data;
                        if_pc    <= pc_inc;
                        if_valid <= 1'b1;
                        if (is_halt) begin
                            state <= ST_HALT;
                        end else begin
                            pc <= pc_inc;
                        end
                    end
                end
                ST_HALT: begin
                    if (pc_redirect) begin
                        pc       <= pc_target;
                        im_instr <= NOP_INSTR;
                        if_valid <= 1'b0;
                        state    <= ST_RUN;
                    end else if (!stall) begin
                        im_instr <= NOP_INSTR;
                        if_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_START;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_step1.sv
// tb/tb_cpu_step1.sv - randomized self-checking bench for cpu_step1 against a fetch-stage model
module tb_cpu_step1;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        pc_redirect;
    logic [9:0]  pc_target;
    logic [9:0]  im_addr;
    logic [15:0] im_data;
    logic [15:0] im_instr;
    logic [9:0]  if_pc;
    logic        if_valid;
    logic        halted;

    logic [15:0] mem [0:1023];

    int errors = 0;
    int checks = 0;

    // Model: fetch mode 0=just out of reset, 1=fetching, 2=stopped on HALT.
    int          m_mode;
    int          m_pc;
    logic [15:0] m_instr;
    int          m_ifpc;
    logic        m_valid;

    cpu_step1 dut (
        .clock      (clock),
        .reset      (reset),
        .stall      (stall),
        .pc_redirect(pc_redirect),
        .pc_target  (pc_target),
        .im_addr    (im_addr),
        .im_data    (im_data),
        .im_instr   (im_instr),
        .if_pc      (if_pc),
        .if_valid   (if_valid),
        .halted     (halted)
    );

    assign im_data = mem[im_addr];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 0;
        m_instr = 16'h0000;
        m_ifpc  = 0;
        m_valid = 1'b0;
    endtask

    task automatic model_edge();
        logic [15:0] d;
        if (m_mode == 0) begin
            m_instr = 16'h0000;
            m_valid = 1'b0;
            m_mode  = 1;
        end else if (pc_redirect) begin
            m_pc    = int'(pc_target);
            m_instr = 16'h0000;
            m_valid = 1'b0;
            m_mode  = 1;
        end else if (!stall) begin
            if (m_mode == 2) begin
                m_instr = 16'h0000;
                m_valid = 1'b0;
            end else begin
                d       = mem[m_pc];
                m_instr = d;
                m_ifpc  = (m_pc + 1) % 1024;
                m_valid = 1'b1;
                if (d[15:10] == 6'h3F) m_mode = 2;
                else m_pc = (m_pc + 1) % 1024;
            end
        end
    endtask

    task automatic compare_all();
        check("im_addr",  32'(im_addr),  32'(m_pc));
        check("im_instr", 32'(im_instr), 32'(m_instr));
        check("if_pc",    32'(if_pc),    32'(m_ifpc));
        check("if_valid", 32'(if_valid), 32'(m_valid));
        check("halted",   32'(halted),   32'(m_mode == 2));
    endtask

    task automatic step(input logic st, input logic rd, input logic [9:0] tgt);
        stall       = st;
        pc_redirect = rd;
        pc_target   = tgt;
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    // Asserts reset mid-cycle, checks the asynchronous effect, releases at the next falling edge.
    task automatic do_reset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, "_addr"},   32'(im_addr),  32'h0);
        check({tag, "_valid"},  32'(if_valid), 32'h0);
        check({tag, "_instr"},  32'(im_instr), 32'h0);
        check({tag, "_halted"}, 32'(halted),   32'h0);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = '0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0100;
        model_reset();

        // Test 1: reset and START.
        mem[0] = 16'h1234;
        #12;
        do_reset("rst0");
        step(1'b1, 1'b1, 10'h155);
        check("t1_start_instr", 32'(im_instr), 32'h0);
        check("t1_start_valid", 32'(if_valid), 32'h0);
        check("t1_start_addr",  32'(im_addr),  32'h0);
        step(1'b0, 1'b0, 10'h0);
        check("t1_instr", 32'(im_instr), 32'h1234);
        check("t1_ifpc",  32'(if_pc),    32'h1);
        check("t1_valid", 32'(if_valid), 32'h1);

        // Tests 2/3: sequential fetch with a two-cycle stall at PC=2.
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333;
        mem[3] = 16'h4444; mem[4] = 16'h5555;
        do_reset("rst1");
        step(1'b0, 1'b0, 10'h0);
        step(1'b0, 1'b0, 10'h0);
        check("t2_instr0", 32'(im_instr), 32'h1111);
        check("t2_ifpc0",  32'(if_pc),    32'h1);
        step(1'b0, 1'b0, 10'h0);
        check("t2_instr1", 32'(im_instr), 32'h2222);
        check("t2_ifpc1",  32'(if_pc),    32'h2);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 10'h0);
            check("t3_addr",  32'(im_addr),  32'h2);
            check("t3_instr", 32'(im_instr), 32'h2222);
            check("t3_ifpc",  32'(if_pc),    32'h2);
        end
        step(1'b0, 1'b0, 10'h0);
        check("t2_instr2", 32'(im_instr), 32'h3333);
        check("t2_ifpc2",  32'(if_pc),    32'h3);
        check("t2_addr",   32'(im_addr),  32'h3);

        // Test 4: redirect with simultaneous stall at PC=5.
        mem[10'h200] = 16'h7A5C;
        step(1'b0, 1'b0, 10'h0);
        step(1'b0, 1'b0, 10'h0);
        check("t4_pc5", 32'(im_addr), 32'h5);
        step(1'b1, 1'b1, 10'h200);
        check("t4_addr",  32'(im_addr),  32'h200);
        check("t4_instr", 32'(im_instr), 32'h0);
        check("t4_valid", 32'(if_valid), 32'h0);
        step(1'b0, 1'b0, 10'h0);
        check("t4_fetch", 32'(im_instr), 32'h7A5C);
        check("t4_ifpc",  32'(if_pc),    32'h201);

        // Test 5: PC wrap at 1023.
        mem[1023] = 16'h0ABC;
        step(1'b0, 1'b1, 10'd1023);
        step(1'b0, 1'b0, 10'h0);
        check("t5_instr", 32'(im_instr), 32'h0ABC);
        check("t5_ifpc",  32'(if_pc),    32'h0);
        check("t5_addr",  32'(im_addr),  32'h0);

        // Test 6: HALT, stalled HALT retained, cancel by redirect, reset mid-run.
        mem[4] = 16'hFC00;
        mem[8] = 16'h0808;
        step(1'b0, 1'b1, 10'h4);
        step(1'b0, 1'b0, 10'h0);
        check("t6_instr",  32'(im_instr), 32'hFC00);
        check("t6_valid",  32'(if_valid), 32'h1);
        check("t6_halted", 32'(halted),   32'h1);
        check("t6_addr",   32'(im_addr),  32'h4);
        step(1'b1, 1'b0, 10'h0);
        check("t6_stall_instr", 32'(im_instr), 32'hFC00);
        step(1'b0, 1'b0, 10'h0);
        check("t6_bubble", 32'(if_valid), 32'h0);
        check("t6_addr2",  32'(im_addr),  32'h4);
        step(1'b0, 1'b1, 10'h8);
        check("t6_run",    32'(halted),   32'h0);
        step(1'b0, 1'b0, 10'h0);
        check("t6_fetch8", 32'(im_instr), 32'h0808);
        do_reset("t6_rst");

        // Randomized phase.
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] v;
            v = 16'($urandom_range(0, 16'hFBFF));
            if ($urandom_range(0, 23) == 0) v = v | 16'hFC00;
            mem[i] = v;
        end
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset("rnd_rst");
            end else begin
                step($urandom_range(0, 3) == 0,
                     $urandom_range(0, 9) == 0,
                     10'($urandom_range(0, 1023)));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_step1.md
Name: cpu_step1

Overview:
Instruction-fetch stage of the 16-bit, 4-register pipelined CPU. It sits directly upstream of the decode/register-read stage (cpu_step2). It owns the program counter and drives the instruction-memory address. It holds the IF/ID pipeline register, whose im_instr output feeds cpu_step2 directly. Stall comes from the hazard logic, redirect (branch/jump) comes from a later stage, and a HALT opcode stops fetch.

Parameters:
PC_W, 10, program counter / instruction address width (matches the 10-bit instr addr field)
DW, 16, instruction width
RESET_PC, 0, PC value after reset
NOP_INSTR, 16'h0000, bubble instruction inserted into IF/ID
HALT_OP, 6'h3F, opcode (instr[15:10]) that stops fetch

Ports:
clock  input  1  single clock; all state on rising edge
reset  input  1  asynchronous, active-low reset (reset==0 resets immediately, independent of clock)
stall  input  1  hold PC and IF/ID this cycle (from hazard logic)
pc_redirect  input  1  load pc_target into PC and squash IF/ID (from branch/jump resolution)
pc_target  input  PC_W  redirect target address
im_addr  output  PC_W  instruction-memory address; combinational, equals PC
im_data  input  DW  instruction-memory read data; combinational, same cycle as im_addr
im_instr  output  DW  IF/ID instruction register; feeds cpu_step2
if_pc  output  PC_W  IF/ID register: address of the fetched instruction + 1
if_valid  output  1  IF/ID holds a real instruction (0 = bubble)
halted  output  1  fetch is stopped by HALT

Behaviour:
- Reset (reset==0, asynchronous): pc=RESET_PC, im_instr=NOP_INSTR, if_pc=0, if_valid=0, halted=0, state=START.
- State machine: START, RUN, HALT.
- START: lasts exactly one cycle after reset deassertion. PC is held and IF/ID loads a bubble. Next state is RUN. stall and pc_redirect are ignored in START.
- RUN, per rising edge, with priority redirect > stall > normal:
  - pc_redirect=1: pc<=pc_target; IF/ID<=bubble (NOP_INSTR, if_valid=0, if_pc unchanged); state stays RUN. This applies even if stall=1 in the same cycle.
  - stall=1 (no redirect): pc, im_instr, if_pc and if_valid all hold.
  - Normal fetch: im_instr<=im_data; if_pc<=pc+1; if_valid<=1; pc<=pc+1.
    - The PC increment wraps modulo 2^PC_W, so 1023 goes to 0.
  - Normal fetch where im_data[15:10]==HALT_OP: the HALT instruction is latched as a valid instruction; pc holds (no increment); state<=HALT.
- HALT:
  - halted=1 combinationally from state.
  - pc holds.
  - With stall=0, IF/ID loads a bubble each edge.
  - With stall=1, IF/ID holds, so a HALT instruction stalled in IF/ID is not lost.
  - pc_redirect=1 (an older branch cancels the speculative HALT): pc<=pc_target, IF/ID<=bubble, state<=RUN, halted drops the following cycle.
  - Only pc_redirect or reset leaves HALT.
- Latency: an instruction at address A appears on im_instr one edge after im_addr==A with stall=0. Steady-state throughput is 1 instruction/cycle.
- im_addr changes only on clock edges or asynchronously on reset. It never glitches from stall or redirect inputs.
- if_pc is fetch address+1. No internal adder is shared with later stages.
- Reset mid-operation: all state returns to reset values immediately. im_addr goes to RESET_PC in the same cycle.
- Out-of-range pc_target is impossible: the target is truncated to PC_W bits by width.

Test Plan:
1. Reset/start: hold reset=0, then release. Required: im_instr=0000, if_valid=0, im_addr=0 during START. Instruction mem[0]=16'h1234 appears on im_instr at the second edge with if_pc=1 and if_valid=1.
2. Sequential fetch: memory holds 0x1111, 0x2222, 0x3333 at 0..2 with no stall. Required: im_instr shows the three values on consecutive edges, if_pc=1,2,3, and im_addr ends at 3.
3. Stall: assert stall for 2 cycles while PC=2. Required: im_addr=2, and im_instr/if_pc stay frozen at 0x2222/2 for both cycles. Fetch resumes with 0x3333.
4. Redirect with simultaneous stall: PC=5, pc_redirect=1, stall=1, pc_target=0x200. Required: next edge gives im_addr=0x200, im_instr=0000, if_valid=0. The next fetch delivers mem[0x200] with if_pc=0x201.
5. Wrap: pc_redirect to 1023 with mem[1023]=0x0ABC. Required: im_instr=0x0ABC, if_pc=0, and im_addr wraps to 0.
6. HALT and cancel:
   - mem[4]=0xFC00 (opcode 3F). Required: latched valid; halted=1 from the next cycle; im_addr stays 4; later IF/ID entries are bubbles.
   - Then pulse pc_redirect with target 8. Required: state returns to RUN and mem[8] is fetched.
   - Then pull reset=0 mid-run. Required: im_addr=0 and if_valid=0 immediately.
